// File: rtl/cache_mem_arbiter_pkg.sv
// Shared cpu types for the cache/RAM arbiter: RAM status codes, grant states
// and the machine word type.
package cache_mem_arbiter_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BUSY   = 2'b01,
        ACCESS = 2'b10,
        ERROR  = 2'b11
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        IGRANT = 2'b01,
        DGRANT = 2'b10
    } arb_state_t;

endpackage

// File: rtl/cache_mem_arbiter.sv
// Shares one RAM port between icache fills and dcache reads/writes. Data side
// wins ties unless the icache has been passed over STARVE_MAX times in a row.
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
);

    arb_state_t         r_state;
    arb_state_t         w_next_state;
    logic [CNT_W-1:0]   r_starve_cnt;
    logic [CNT_W-1:0]   w_starve_nxt;
    logic               w_access;
    logic               w_starved;
    logic               w_dreq;

    assign w_access  = (ramstate == ACCESS);
    assign w_starved = (r_starve_cnt == CNT_W'(STARVE_MAX));
    assign w_dreq    = dREN | dWEN;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state      <= IDLE;
            r_starve_cnt <= '0;
        end else begin
            r_state      <= w_next_state;
            r_starve_cnt <= w_starve_nxt;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_starve_nxt = r_starve_cnt;
        ramREN       = 1'b0;
        ramWEN       = 1'b0;
        ramaddr      = '0;
        ramstore     = '0;
        iwait        = 1'b1;
        dwait        = 1'b1;
        iload        = '0;
        dload        = '0;

        case (r_state)
            IDLE: begin
                // Every grant starts here, so enables always drop for a cycle
                // between transactions.
                if (w_dreq && !(iREN && w_starved))
                    w_next_state = DGRANT;
                else if (iREN)
                    w_next_state = IGRANT;
            end

            IGRANT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                if (!iREN) begin
                    w_next_state = IDLE;
                end else if (w_access) begin
                    iwait        = 1'b0;
                    iload        = ramload;
                    w_next_state = IDLE;
                    w_starve_nxt = '0;
                end
            end

            DGRANT: begin
                ramREN   = dREN;
                ramWEN   = dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                if (!w_dreq) begin
                    w_next_state = IDLE;
                end else if (w_access) begin
                    dwait        = 1'b0;
                    if (dREN)
                        dload = ramload;
                    w_next_state = IDLE;
                    // Only passes over a waiting ifetch count toward starvation.
                    if (!iREN)
                        w_starve_nxt = '0;
                    else if (!w_starved)
                        w_starve_nxt = r_starve_cnt + CNT_W'(1);
                end
            end

            default: w_next_state = IDLE;
        endcase
    end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Sequences and shares the single RAM port between the instruction cache (read-only) and the data cache (read/write).
- Sits between the icache/dcache miss-fill interfaces and the RAM model.
- Registered grant state machine: a granted transfer is never preempted.
- Data side has priority, with a starvation bound that protects instruction fetch.

Parameters:
- STARVE_MAX, 4, number of consecutive dcache grants allowed while iREN is pending before the icache is forced to win.
- CNT_W, 3, width of the starvation counter; must satisfy 2^CNT_W > STARVE_MAX.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- iREN  in  1  icache read request.
- iaddr  in  32  icache word address.
- iwait  out  1  low only in the cycle the icache read completes.
- iload  out  32  icache read data, valid when iwait=0.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request; dREN and dWEN both high is illegal.
- daddr  in  32  dcache word address.
- dstore  in  32  dcache write data.
- dwait  out  1  low only in the cycle the dcache transfer completes.
- dload  out  32  dcache read data, valid when dwait=0.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  RAM status: FREE, BUSY, ACCESS, ERROR.

Behaviour:
- Reset: all ports below are asynchronous on nRST low.
  - state=IDLE, starve_cnt=0.
  - ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
  - iwait=1, dwait=1, iload=0, dload=0.
- States: IDLE, IGRANT, DGRANT.
- IDLE:
  - No RAM enables asserted; iwait=dwait=1.
  - Next state on the clock edge:
    - (dREN|dWEN) and !(iREN and starve_cnt==STARVE_MAX) -> DGRANT.
    - else if iREN -> IGRANT.
    - else stay IDLE.
  - Minimum latency: request in cycle 0, RAM driven in cycle 1.
- IGRANT:
  - ramREN=iREN, ramaddr=iaddr, ramWEN=0.
  - ramstate==ACCESS and iREN: iwait=0, iload=ramload (combinational); next IDLE; starve_cnt <= 0.
  - iREN deasserts: abort; RAM enables drop that same cycle; next IDLE; no completion reported.
  - BUSY, FREE or ERROR: iwait=1 and hold; ERROR is treated as a retry.
- DGRANT:
  - ramREN=dREN, ramWEN=dWEN, ramaddr=daddr, ramstore=dstore.
  - ramstate==ACCESS and (dREN|dWEN): dwait=0; dload=ramload on reads; next IDLE.
  - starve_cnt update on completion:
    - iREN high: starve_cnt <= starve_cnt+1, saturating at STARVE_MAX.
    - iREN low: starve_cnt <= 0.
  - Abort and retry rules are the same as IGRANT.
- Grant is sticky: a request arriving during a grant waits; no preemption.
- Output gating:
  - The wait output of the non-granted requester is always 1.
  - Its load output holds 0.
- Back-to-back transfers: after a completion, one IDLE cycle is required before the next grant. The IDLE bubble is mandatory; it guarantees the RAM sees enables drop between transactions.
- Simultaneous iREN and dREN in IDLE with starve_cnt<STARVE_MAX -> DGRANT.
- Simultaneous iREN and dREN in IDLE with starve_cnt==STARVE_MAX -> IGRANT.
- Addresses and data pass through unmodified; no width conversion.
- Reset asserted mid-transfer: immediate return to IDLE and enables drop; the requester must re-request.

Decomposition:
- Shared cpu types package:
  - ramstate_t enum (FREE, BUSY, ACCESS, ERROR).
  - arb_state_t enum (IDLE, IGRANT, DGRANT).
  - word_t (32-bit).
- Interface bundle: existing caches_if style carrying iREN/iwait/iload/iaddr/dREN/dWEN/dwait/dload/daddr/dstore plus the ram* signals.
- No sub-module: the FSM, starvation counter and output mux stay in one module.

Test Plan:
- Single ifetch: iREN=1, iaddr=0x40, RAM returns ACCESS 2 cycles after ramREN with ramload=0x8C220004.
  - Required: ramREN high cycles 1–3; iwait=0 and iload=0x8C220004 in cycle 3; IDLE in cycle 4.
- Contention: iREN=dREN=1 at cycle 0, starve_cnt=0.
  - Required: DGRANT first; dwait low first; then one IDLE cycle; then IGRANT; iwait low afterward.
- Starvation: iREN held high, dWEN held high for 6 transfers, STARVE_MAX=4.
  - Required: exactly 4 dcache completions, then the icache completes, then dcache grants resume.
- Abort: dREN drops during DGRANT while ramstate=BUSY.
  - Required: ramREN=0 in that same cycle; IDLE next cycle; dwait stays 1.
- Write path: dWEN=1, daddr=0x100, dstore=0xDEADBEEF.
  - Required: ramWEN=1, ramaddr=0x100, ramstore=0xDEADBEEF until ACCESS; ramREN stays 0 throughout.
- Mid-transfer reset: nRST low during IGRANT with BUSY.
  - Required: ramREN=0 and iwait=1 immediately; state IDLE; starve_cnt=0.
